tl_a_get_fragmenter_ctrl: RTL and testbench
===========================================

Name: tl_a_get_fragmenter_ctrl

Overview:
- Sequencing controller between a TileLink-A request repeater's dequeue side and a narrow downstream A-channel port.
- Splits a Get larger than 2^LG_FRAG bytes into 2^(size-LG_FRAG) single-beat Gets of size LG_FRAG, stepping the address.
- Drives the repeater's repeat input to hold the original request until the last fragment is issued.
- Passes every other request through unchanged.

Parameters:
- LG_FRAG, 3, log2 of fragment size in bytes; equals log2 of the mask width (8 bytes).
- MAX_LG_SIZE, 7, largest legal request size; the fragment counter is MAX_LG_SIZE-LG_FRAG = 4 bits.

Ports:
- clock  in  1  Clock.
- reset  in  1  Reset; synchronous, active-high.
- rep_full  in  1  Repeater holding a saved request; used only for checking.
- rep_valid  in  1  Repeater dequeue valid.
- rep_ready  out  1  Repeater dequeue ready.
- rep_repeat  out  1  Repeat request to the repeater.
- rep_opcode, rep_param, rep_size  in  3 each  Request fields from the repeater.
- rep_source  in  7  Request field from the repeater.
- rep_address  in  17  Request field from the repeater.
- rep_mask  in  8  Request field from the repeater.
- rep_corrupt  in  1  Request field from the repeater.
- out_valid  out  1  Downstream A valid.
- out_ready  in  1  Downstream A ready.
- out_opcode, out_param, out_size  out  3 each  Fragment fields.
- out_source  out  7  Fragment field.
- out_address  out  17  Fragment field.
- out_mask  out  8  Fragment field.
- out_corrupt  out  1  Fragment field.
- out_frag_idx  out  4  Index of the fragment, for D-side reassembly.
- out_frag_last  out  1  High on the final fragment or on a passthrough request.

Behaviour:
- Fragment condition: frag = rep_valid & rep_opcode==4 (Get) & rep_size>LG_FRAG. All arithmetic is unsigned.
- nfrag-1 = (1<<(rep_size-LG_FRAG))-1, 4 bits.
- State: a 4-bit count register and a busy flag. Reset (synchronous, active-high) sets count=0 and busy=0.
- The block has no outputs that depend on registers other than count and busy. With rep_valid=0 at reset exit, all outputs are 0.
- Handshake: out_valid = rep_valid and rep_ready = out_ready, both purely combinational, so there is zero added latency.
  - A fire is out_valid & out_ready.
  - out_valid never depends on out_ready.
- Fields when frag=1:
  - out_size = LG_FRAG.
  - out_address = rep_address + (count << LG_FRAG), truncated to 17 bits.
  - out_mask = 8'hFF.
  - out_frag_idx = count.
  - out_frag_last = (count == nfrag-1).
  - out_opcode, out_param, out_source and out_corrupt pass through.
- Fields when frag=0: all fields pass through, out_frag_idx = 0, out_frag_last = 1.
- rep_repeat = frag & ~out_frag_last. It is combinational and sampled by the repeater on the same fire.
- Count update:
  - On a fire with frag & ~last: count <= count+1 and busy <= 1.
  - On a fire with frag & last: count <= 0 and busy <= 0.
  - No change otherwise, including while out_ready is low.
- Stall: with out_ready low mid-sequence, count holds and out_address is stable.
- Boundary at rep_size == LG_FRAG+1: there are 2 fragments.
- Boundary at rep_size == MAX_LG_SIZE: there are 16 fragments, and count wraps 15->0 on the last fire.
- Mid-sequence the request comes from the repeater's saved copy. This is checked in simulation only: busy & rep_valid implies rep_full.
- Reset mid-sequence: count and busy clear on the next edge. The repeater is reset by the same reset, so no partial sequence resumes.
- A Get with size <= LG_FRAG, and any Put, Atomic or Hint, is a single passthrough transfer with rep_repeat=0.

Optional Feature:
- Macro: TL_A_FRAG_PERF_EN.
- When defined, the block adds output ports perf_req_cnt (32 bits) and perf_frag_cnt (32 bits).
  - perf_req_cnt increments on each frag & last fire.
  - perf_frag_cnt increments on each fragment fire where frag=1.
  - Both counters clear on reset and wrap modulo 2^32.
- When undefined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Get, size=5, address=0x100, out_ready=1 -> 4 fires at addresses 0x100, 0x108, 0x110, 0x118, all with size=3 and mask=0xFF. rep_repeat is 1,1,1,0; out_frag_last only on idx 3; count=0 afterwards.
- Get, size=3, address=0x40 -> 1 fire, fields unchanged, rep_repeat=0, out_frag_idx=0, out_frag_last=1.
- PutFull (opcode 0), size=6 -> passthrough on every beat with rep_repeat=0 and out_size=6.
- Get, size=4, out_ready low for 3 cycles before the second fragment -> address holds at base+8 and count stays 1 during the stall, then last fires.
- Get, size=7, address=0x1F80 -> 16 fragments, the last at 0x1FF8; count wraps to 0.
- Reset asserted after the 2nd fragment of a size=6 Get -> count=0 and busy=0 next cycle. A following size=3 Get is a passthrough. With TL_A_FRAG_PERF_EN defined, perf_req_cnt=0 and perf_frag_cnt=0 after reset.

Source files
------------

// File: rtl/tl_a_get_fragmenter_ctrl_if.sv
// Bundle of the repeater dequeue side and the narrow downstream A-channel
// port seen by tl_a_get_fragmenter_ctrl. The slave modport is the
// controller's view; the master modport is the surrounding logic's view.
interface tl_a_get_fragmenter_ctrl_if;
   // Repeater dequeue side
   logic        rep_full;
   logic        rep_valid;
   logic        rep_ready;
   logic        rep_repeat;
   logic [2:0]  rep_opcode;
   logic [2:0]  rep_param;
   logic [2:0]  rep_size;
   logic [6:0]  rep_source;
   logic [16:0] rep_address;
   logic [7:0]  rep_mask;
   logic        rep_corrupt;
   // Downstream A channel
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_opcode;
   logic [2:0]  out_param;
   logic [2:0]  out_size;
   logic [6:0]  out_source;
   logic [16:0] out_address;
   logic [7:0]  out_mask;
   logic        out_corrupt;
   logic [3:0]  out_frag_idx;
   logic        out_frag_last;

   modport slave (
      input  rep_full, rep_valid, rep_opcode, rep_param, rep_size, rep_source,
             rep_address, rep_mask, rep_corrupt, out_ready,
      output rep_ready, rep_repeat, out_valid, out_opcode, out_param, out_size,
             out_source, out_address, out_mask, out_corrupt, out_frag_idx,
             out_frag_last
   );

   modport master (
      output rep_full, rep_valid, rep_opcode, rep_param, rep_size, rep_source,
             rep_address, rep_mask, rep_corrupt, out_ready,
      input  rep_ready, rep_repeat, out_valid, out_opcode, out_param, out_size,
             out_source, out_address, out_mask, out_corrupt, out_frag_idx,
             out_frag_last
   );
endinterface

// File: rtl/tl_a_get_fragmenter_ctrl.sv
// tl_a_get_fragmenter_ctrl: splits Gets larger than 2^LG_FRAG bytes into
// single-beat Gets of 2^LG_FRAG bytes, holding the original request in the
// upstream repeater (via rep_repeat) until the last fragment is issued.
// All other requests pass straight through. Handshake is combinational.
// Optional: define TL_A_FRAG_PERF_EN to add perf_req_cnt/perf_frag_cnt.

// Simulation-only check: mid-sequence the request must come from the
// repeater's saved copy.
module tl_a_get_fragmenter_ctrl_chk (
   input logic clock,
   input logic reset,
   input logic busy,
   input logic rep_valid,
   input logic rep_full
);
   a_busy_from_saved: assert property (@(posedge clock) disable iff (reset)
      (busy && rep_valid) |-> rep_full);
endmodule

module tl_a_get_fragmenter_ctrl #(
   parameter int LG_FRAG     = 3,
   parameter int MAX_LG_SIZE = 7
) (
   input logic clock,
   input logic reset,
   tl_a_get_fragmenter_ctrl_if.slave bus
`ifdef TL_A_FRAG_PERF_EN
   ,
   output logic [31:0] perf_req_cnt,
   output logic [31:0] perf_frag_cnt
`endif
);
   localparam int CW = MAX_LG_SIZE - LG_FRAG;

   logic [CW-1:0] count_r;
   logic          busy_r;
   logic          frag_s;
   logic          fire_s;
   logic          last_s;
   logic [2:0]    shift_s;
   logic [CW:0]   pow_s;
   logic [CW-1:0] nfrag_m1_s;
   logic [16:0]   addr_off_s;

   // Decode whether the current request is fragmented and where it ends
   always_comb begin
      frag_s     = bus.rep_valid & (bus.rep_opcode == 3'd4) &
                   (bus.rep_size > 3'(LG_FRAG));
      fire_s     = bus.rep_valid & bus.out_ready;
      // Wraps for small sizes; only meaningful when frag_s is set
      shift_s    = bus.rep_size - 3'(LG_FRAG);
      pow_s      = {{CW{1'b0}}, 1'b1} << shift_s;
      nfrag_m1_s = CW'(pow_s - {{CW{1'b0}}, 1'b1});
      last_s     = (count_r == nfrag_m1_s);
      addr_off_s = 17'(count_r) << LG_FRAG;
   end

   // Build the outgoing beat: fragment fields or plain passthrough
   always_comb begin
      bus.out_valid   = bus.rep_valid;
      bus.rep_ready   = bus.out_ready;
      bus.out_opcode  = bus.rep_opcode;
      bus.out_param   = bus.rep_param;
      bus.out_source  = bus.rep_source;
      bus.out_corrupt = bus.rep_corrupt;
      bus.rep_repeat  = frag_s & ~last_s;
      if (frag_s) begin
         bus.out_size      = 3'(LG_FRAG);
         bus.out_address   = bus.rep_address + addr_off_s;
         bus.out_mask      = 8'hFF;
         bus.out_frag_idx  = 4'(count_r);
         bus.out_frag_last = last_s;
      end else begin
         bus.out_size      = bus.rep_size;
         bus.out_address   = bus.rep_address;
         bus.out_mask      = bus.rep_mask;
         bus.out_frag_idx  = 4'd0;
         // No request, no "last" flag: keeps an idle port all-zero
         bus.out_frag_last = bus.rep_valid;
      end
   end

   // Fragment counter and busy flag advance only on fragment fires
   always_ff @(posedge clock) begin
      if (reset) begin
         count_r <= {CW{1'b0}};
         busy_r  <= 1'b0;
      end else if (fire_s & frag_s) begin
         if (last_s) begin
            count_r <= {CW{1'b0}};
            busy_r  <= 1'b0;
         end else begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            busy_r  <= 1'b1;
         end
      end
   end

`ifdef TL_A_FRAG_PERF_EN
   // Count completed fragmented requests and individual fragment beats
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_req_cnt  <= 32'd0;
         perf_frag_cnt <= 32'd0;
      end else if (fire_s & frag_s) begin
         perf_frag_cnt <= perf_frag_cnt + 32'd1;
         if (last_s) begin
            perf_req_cnt <= perf_req_cnt + 32'd1;
         end
      end
   end
`endif

   tl_a_get_fragmenter_ctrl_chk u_chk (
      .clock     (clock),
      .reset     (reset),
      .busy      (busy_r),
      .rep_valid (bus.rep_valid),
      .rep_full  (bus.rep_full)
   );
endmodule

// File: tb/tb_tl_a_get_fragmenter_ctrl.sv
// Self-checking bench for tl_a_get_fragmenter_ctrl. The bench plays the
// repeater: it holds each request until the expected number of beats has
// fired and compares every presented beat against fields computed from the
// fragmentation rules (beat i of n at base + 8*i).
module tb_tl_a_get_fragmenter_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_req_cnt  = 0;
   int   exp_frag_cnt = 0;

   tl_a_get_fragmenter_ctrl_if bus ();

`ifdef TL_A_FRAG_PERF_EN
   logic [31:0] perf_req_cnt;
   logic [31:0] perf_frag_cnt;
`endif

   tl_a_get_fragmenter_ctrl #(.LG_FRAG(3), .MAX_LG_SIZE(7)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
`ifdef TL_A_FRAG_PERF_EN
      ,
      .perf_req_cnt  (perf_req_cnt),
      .perf_frag_cnt (perf_frag_cnt)
`endif
   );

   always #5 clock = ~clock;

   // Hard time limit so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "time limit reached");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_perf();
`ifdef TL_A_FRAG_PERF_EN
      check_eq("perf_req",  perf_req_cnt,  32'(exp_req_cnt));
      check_eq("perf_frag", perf_frag_cnt, 32'(exp_frag_cnt));
`endif
   endtask

   task automatic idle(input int k);
      for (int c = 0; c < k; c++) begin
         @(negedge clock);
         bus.rep_valid = 1'b0;
         bus.rep_full  = 1'b0;
         bus.out_ready = 1'($urandom_range(0, 1));
         #1;
         check_eq("idle_valid",  32'(bus.out_valid),  32'd0);
         check_eq("idle_repeat", 32'(bus.rep_repeat), 32'd0);
      end
   endtask

   // Present one request and follow it to completion (or abort_after fires).
   // stall_before/stall_len force out_ready low before that beat index;
   // rnd adds bounded random back-pressure.
   task automatic run_req(input logic [2:0] op, input logic [2:0] prm,
                          input logic [2:0] sz, input logic [6:0] src,
                          input logic [16:0] addr, input logic [7:0] msk,
                          input logic cor, input int stall_before,
                          input int stall_len, input bit rnd,
                          input int abort_after);
      bit          fragd;
      int          n;
      int          i = 0;
      int          stalls = 0;
      int          rstalls = 0;
      bit          first = 1'b1;
      logic [16:0] ea;
      fragd = (op == 3'd4) && (sz > 3'd3);
      n = fragd ? (1 << (int'(sz) - 3)) : 1;
      while (i < n && i != abort_after) begin
         @(negedge clock);
         if (first) begin
            bus.rep_opcode  = op;
            bus.rep_param   = prm;
            bus.rep_size    = sz;
            bus.rep_source  = src;
            bus.rep_address = addr;
            bus.rep_mask    = msk;
            bus.rep_corrupt = cor;
            bus.rep_valid   = 1'b1;
            first = 1'b0;
         end
         bus.rep_full = (i > 0);
         if (i == stall_before && stalls < stall_len) begin
            bus.out_ready = 1'b0;
            stalls++;
         end else if (rnd && rstalls < 4 && $urandom_range(0, 3) == 0) begin
            bus.out_ready = 1'b0;
            rstalls++;
         end else begin
            bus.out_ready = 1'b1;
            rstalls = 0;
         end
         #1;
         ea = fragd ? (addr + 17'(i * 8)) : addr;
         check_eq("valid",   32'(bus.out_valid), 32'd1);
         check_eq("ready",   32'(bus.rep_ready), 32'(bus.out_ready));
         check_eq("address", 32'(bus.out_address), 32'(ea));
         check_eq("size",    32'(bus.out_size), fragd ? 32'd3 : 32'(sz));
         check_eq("mask",    32'(bus.out_mask), fragd ? 32'hFF : 32'(msk));
         check_eq("idx",     32'(bus.out_frag_idx), fragd ? 32'(i) : 32'd0);
         check_eq("last",    32'(bus.out_frag_last),
                  (!fragd || i == n - 1) ? 32'd1 : 32'd0);
         check_eq("repeat",  32'(bus.rep_repeat),
                  (fragd && i != n - 1) ? 32'd1 : 32'd0);
         check_eq("passthru",
                  32'({bus.out_opcode, bus.out_param, bus.out_source, bus.out_corrupt}),
                  32'({op, prm, src, cor}));
         if (bus.out_ready) begin
            i++;
            if (fragd) begin
               exp_frag_cnt++;
               if (i == n) exp_req_cnt++;
            end
         end
      end
   endtask

   initial begin
      bus.rep_full = 1'b0;    bus.rep_valid = 1'b0;  bus.out_ready = 1'b0;
      bus.rep_opcode = 3'd0;  bus.rep_param = 3'd0;  bus.rep_size = 3'd0;
      bus.rep_source = 7'd0;  bus.rep_address = 17'd0;
      bus.rep_mask = 8'd0;    bus.rep_corrupt = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      // Idle port after reset is all-zero
      check_eq("rst_valid",  32'(bus.out_valid),     32'd0);
      check_eq("rst_ready",  32'(bus.rep_ready),     32'd0);
      check_eq("rst_repeat", 32'(bus.rep_repeat),    32'd0);
      check_eq("rst_idx",    32'(bus.out_frag_idx),  32'd0);
      check_eq("rst_last",   32'(bus.out_frag_last), 32'd0);
      check_eq("rst_addr",   32'(bus.out_address),   32'd0);
      check_eq("rst_mask",   32'(bus.out_mask),      32'd0);
      check_perf();

      // Directed scenarios
      run_req(3'd4, 3'd0, 3'd5, 7'h11, 17'h00100, 8'h0F, 1'b0, -1, 0, 0, -1);
      run_req(3'd4, 3'd0, 3'd3, 7'h12, 17'h00040, 8'hF0, 1'b0, -1, 0, 0, -1);
      run_req(3'd0, 3'd0, 3'd6, 7'h13, 17'h00200, 8'hFF, 1'b1, -1, 0, 0, -1);
      run_req(3'd4, 3'd2, 3'd4, 7'h14, 17'h00300, 8'h00, 1'b0, 1, 3, 0, -1);
      run_req(3'd4, 3'd0, 3'd7, 7'h15, 17'h01F80, 8'h00, 1'b0, -1, 0, 0, -1);
      run_req(3'd4, 3'd0, 3'd4, 7'h16, 17'h1FFF8, 8'h00, 1'b0, -1, 0, 0, -1);
      idle(2);
      check_perf();

      // Reset in the middle of a size-6 Get, after two fragments
      run_req(3'd4, 3'd0, 3'd6, 7'h20, 17'h04000, 8'h00, 1'b0, -1, 0, 0, 2);
      @(negedge clock);
      reset = 1'b1;
      bus.rep_valid = 1'b0;
      bus.rep_full  = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      exp_req_cnt  = 0;
      exp_frag_cnt = 0;
      #1;
      check_perf();
      run_req(3'd4, 3'd0, 3'd3, 7'h21, 17'h00080, 8'hAA, 1'b0, -1, 0, 0, -1);
      run_req(3'd4, 3'd0, 3'd6, 7'h22, 17'h04000, 8'h00, 1'b0, -1, 0, 0, -1);
      idle(1);

      // Randomized traffic, mostly Gets of all sizes
      for (int r = 0; r < 60; r++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 5)) : 3'd4;
         run_req(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 7'($urandom), 17'($urandom), 8'($urandom), 1'($urandom),
                 -1, 0, 1, -1);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);
      check_perf();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
